sram_nr1w: RTL and testbench

Parametrised multi-read, single-write working memory; successor of the fixed 8K×128 2R+1W memory used by the solver datapath. Adds a configurable number of read ports, registered reads with a valid strobe, per-byte write enables, read-during-write forwarding, and a hardware clear engine that zero-fills the array after reset or on request. It sits between the relaxation pipeline (readers) and the update stage (writer).

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_clear_fsm.sv | 73 +++++++
 rtl/sram_nr1w.sv | 126 ++++++++++++
 tb/tb_sram_nr1w.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the multi-read, single-write working memory.
package sram_pkg;

  // Clear engine states.
  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_DEPTH  = 8192;
  localparam int unsigned DEF_NUM_RD = 2;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned num_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: zero-fills the array one word per cycle after reset or on request,
// and presents that activity as a write port that overrides the user port.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clear_req,
  output logic                           init_busy,
  output logic                           clr_we,
  output logic [ADDR_W-1:0]              clr_addr,
  output logic [DATA_W-1:0]              clr_data,
  output logic [num_lanes(DATA_W)-1:0]   clr_be
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam clr_state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a request in READY starts a sweep; requests during a sweep are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      READY: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear write port: whole zero word at the counter address every sweep cycle.
  always_comb begin
    init_busy = (state_q == CLEAR);
    clr_we    = init_busy;
    clr_addr  = cnt_q;
    clr_data  = '0;
    clr_be    = '1;
  end

endmodule

// File: rtl/sram_nr1w.sv
// Parametrised NUM_RD-read / 1-write working memory with byte enables,
// registered reads with valid strobes, write-first forwarding and a clear engine.
module sram_nr1w
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned NUM_RD         = DEF_NUM_RD,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [num_lanes(DATA_W)-1:0]  wr_be,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  input  logic                          clear_req,
  output logic                          init_busy
);

  localparam int unsigned LANES = num_lanes(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic [LANES-1:0]  clr_be;

  logic              wr_in_range;
  logic              user_wr;
  logic [IDX_W-1:0]  wp_idx;
  logic [DATA_W-1:0] wp_data;
  logic [LANES-1:0]  wp_be;

  sram_clear_fsm #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data),
    .clr_be    (clr_be)
  );

  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign user_wr     = !init_busy && we && wr_in_range;

  // Write port mux: the clear engine owns the port while it runs.
  always_comb begin
    wp_idx  = '0;
    wp_data = '0;
    wp_be   = '0;
    if (clr_we) begin
      wp_idx  = clr_addr[IDX_W-1:0];
      wp_data = clr_data;
      wp_be   = clr_be;
    end else if (user_wr) begin
      wp_idx  = wr_addr[IDX_W-1:0];
      wp_data = wr_data;
      wp_be   = wr_be;
    end
  end

  // Byte-lane array update; the array itself is never reset.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wp_be[k]) mem_q[wp_idx][8*k +: 8] <= wp_data[8*k +: 8];
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic              fwd;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign fwd      = user_wr && (wr_addr == addr);

    // Read lookup with write-first byte merge; out-of-range reads return zero.
    always_comb begin
      valid_d = 1'b0;
      data_d  = data_q;
      if (!init_busy && rd_en[p]) begin
        valid_d = 1'b1;
        data_d  = '0;
        if (in_range) begin
          data_d = mem_q[addr[IDX_W-1:0]];
          for (int unsigned k = 0; k < LANES; k++) begin
            if (fwd && wr_be[k]) data_d[8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
    end

    // Output register: data holds when the port is idle.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_valid[p]                 = valid_q;
  end

endmodule

// File: tb/tb_sram_nr1w.sv
// Directed bench for sram_nr1w with a word-level reference model checked every cycle.
module tb_sram_nr1w;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;
  localparam int NR  = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW/8-1:0]  wr_be;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             clear_req;
  logic             init_busy;

  int checks = 0;
  int errors = 0;

  sram_nr1w #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .DEPTH          (DEP),
    .NUM_RD         (NR),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clear_req (clear_req),
    .init_busy (init_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, remaining sweep cycles, expected outputs.
  logic [DW-1:0]    m_mem [DEP];
  int               busy_left = DEP;
  logic [NR-1:0]    e_valid = '0;
  logic [NR*DW-1:0] e_data = '0;

  initial begin
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        busy_left = DEP;
        e_valid   = '0;
        e_data    = '0;
      end else if (busy_left > 0) begin
        busy_left--;
        e_valid = '0;
        if (busy_left == 0) for (int i = 0; i < DEP; i++) m_mem[i] = '0;
      end else begin
        logic [DW-1:0] w;
        if (we && wr_addr < DEP) begin
          w = m_mem[wr_addr[3:0]];
          for (int k = 0; k < DW/8; k++) if (wr_be[k]) w[8*k +: 8] = wr_data[8*k +: 8];
          m_mem[wr_addr[3:0]] = w;
        end
        for (int p = 0; p < NR; p++) begin
          logic [AW-1:0] a;
          e_valid[p] = rd_en[p];
          if (rd_en[p]) begin
            a = rd_addr[p*AW +: AW];
            e_data[p*DW +: DW] = (a < DEP) ? m_mem[a[3:0]] : '0;
          end
        end
        if (clear_req) busy_left = DEP;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("model_busy", 64'(init_busy), 64'(busy_left > 0));
      check("model_valid", 64'(rd_valid), 64'(e_valid));
      check("model_data", rd_data, e_data);
    end
  end

  task automatic idle();
    we = 1'b0; wr_be = '0; rd_en = '0; clear_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clock);
    we = 1'b0; wr_be = '0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en = en; rd_addr = {a1, a0};
    @(negedge clock);
    rd_en = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (init_busy && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  int n;
  int pulses;

  initial begin
    idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(init_busy), 64'd1);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", rd_data, 64'd0);

    // Accesses presented during the sweep must be ignored.
    rd_en = 2'b11; rd_addr = {5'd1, 5'd2};
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    reset_n = 1'b1;
    wait_ready(n);
    idle();
    check("sweep_len_reset", 64'(n), 64'd16);

    for (int i = 0; i < DEP; i++) begin
      rd_en = 2'b11; rd_addr = {5'(DEP - 1 - i), 5'(i)};
      @(negedge clock);
      check("cleared_read", rd_data, 64'd0);
      check("cleared_valid", 64'(rd_valid), 64'd3);
    end
    idle();

    // Byte-enable merge.
    wr(5'd5, 32'hAAAA_AAAA, 4'hF);
    wr(5'd5, 32'h5555_5555, 4'h1);
    rd(2'b11, 5'd5, 5'd5);
    check("byte_merge", rd_data, {2{32'hAAAA_AA55}});

    // Same-edge write and read: write-first forwarding on both ports.
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFF_1234; wr_be = 4'h3;
    rd(2'b11, 5'd7, 5'd7);
    we = 1'b0; wr_be = '0;
    check("fwd_data", rd_data, {2{32'h0000_1234}});
    check("fwd_valid", 64'(rd_valid), 64'd3);

    // Single-cycle valid pulse, data held afterwards.
    wr(5'd3, 32'h0BAD_CAFE, 4'hF);
    rd(2'b01, 5'd3, 5'd9);
    pulses = int'(rd_valid[0]);
    rd_addr = {5'd5, 5'd5};
    repeat (3) begin
      @(negedge clock);
      pulses += int'(rd_valid[0]);
    end
    check("valid_pulse", 64'(pulses), 64'd1);
    check("held_data", 64'(rd_data[31:0]), 64'h0BAD_CAFE);

    // Out-of-range write dropped, out-of-range read returns zero, empty-BE write is a no-op.
    wr(5'd21, 32'hDEAD_BEEF, 4'hF);
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h0; wr_be = 4'h0;
    rd(2'b11, 5'd5, 5'd20);
    we = 1'b0;
    check("oor_data", rd_data, {32'h0, 32'hAAAA_AA55});
    check("oor_valid", 64'(rd_valid), 64'd3);
    rd(2'b01, 5'd7, 5'd0);
    check("be0_noop", 64'(rd_data[31:0]), 64'h0000_1234);

    // Requested clear, with a second request mid-sweep that must not restart it.
    for (int i = 0; i < 4; i++) wr(5'(i), 32'h1111_1111 * (i + 1), 4'hF);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      clear_req = (n == 5);
      @(negedge clock);
    end
    clear_req = 1'b0;
    check("sweep_len_req", 64'(n), 64'd16);
    for (int i = 0; i < 4; i++) begin
      rd(2'b11, 5'(i), 5'(3 - i));
      check("post_clear_read", rd_data, 64'd0);
    end

    // Reset in the middle of a sweep.
    wr(5'd2, 32'hCAFE_F00D, 4'hF);
    rd(2'b11, 5'd2, 5'd2);
    check("pre_reset_data", rd_data, {2{32'hCAFE_F00D}});
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(init_busy), 64'd1);
    check("midrst_valid", 64'(rd_valid), 64'd0);
    check("midrst_data", rd_data, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n);
    check("sweep_len_rerun", 64'(n), 64'd16);
    rd(2'b11, 5'd2, 5'd3);
    check("rerun_cleared", rd_data, 64'd0);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
